// File: rtl/ro_puf_response_engine.sv
// Ring-oscillator PUF response engine. For each challenge pair in a batch it counts
// the synchronised rising edges of two oscillators over a fixed window and compares them.
module ro_puf_response_engine #(
  parameter int unsigned NUM_RO    = 16,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned WINDOW    = 1024,
  parameter int unsigned NUM_PAIRS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RO-1:0]          RO_out,
  input  logic                       start,
  input  logic [NUM_PAIRS*SEL_W-1:0] Cha0,
  input  logic [NUM_PAIRS*SEL_W-1:0] Cha1,
  output logic                       busy,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [NUM_PAIRS-1:0]       Response,
  output logic [NUM_PAIRS-1:0]       Tie
);

  localparam int unsigned CHA_W  = NUM_PAIRS * SEL_W;
  localparam int unsigned SEL_N  = 1 << SEL_W;
  localparam int unsigned WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned PIDX_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t             state;
  logic [CHA_W-1:0]   cha0_q;
  logic [CHA_W-1:0]   cha1_q;
  logic [PIDX_W-1:0]  pidx;
  logic [SEL_W-1:0]   sel0;
  logic [SEL_W-1:0]   sel1;
  logic [CNT_W-1:0]   cnt0;
  logic [CNT_W-1:0]   cnt1;
  logic [WIN_W-1:0]   win;

  logic [NUM_RO-1:0]  sync1;
  logic [NUM_RO-1:0]  sync2;
  logic [NUM_RO-1:0]  prev;
  logic [SEL_N-1:0]   rise_c;
  logic               edge0_c;
  logic               edge1_c;

  // Free-running synchroniser and edge-history stages for every oscillator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= RO_out;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Indices beyond the oscillator array read as a constant-zero input
  always_comb begin
    rise_c             = '0;
    rise_c[NUM_RO-1:0] = sync2 & ~prev;
  end

  assign edge0_c = rise_c[sel0];
  assign edge1_c = rise_c[sel1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cha0_q     <= '0;
      cha1_q     <= '0;
      pidx       <= '0;
      sel0       <= '0;
      sel1       <= '0;
      cnt0       <= '0;
      cnt1       <= '0;
      win        <= '0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      Response   <= '0;
      Tie        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cha0_q <= Cha0;
            cha1_q <= Cha1;
            pidx   <= '0;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end

        S_LOAD: begin
          sel0  <= cha0_q[pidx*SEL_W +: SEL_W];
          sel1  <= cha1_q[pidx*SEL_W +: SEL_W];
          cnt0  <= '0;
          cnt1  <= '0;
          win   <= '0;
          state <= S_COUNT;
        end

        S_COUNT: begin
          if (edge0_c && (cnt0 != CNT_MAX)) cnt0 <= cnt0 + CNT_W'(1);
          if (edge1_c && (cnt1 != CNT_MAX)) cnt1 <= cnt1 + CNT_W'(1);
          if (win == WIN_LAST) begin
            state <= S_COMPARE;
          end else begin
            win <= win + WIN_W'(1);
          end
        end

        S_COMPARE: begin
          Response[pidx] <= (cnt0 > cnt1);
          Tie[pidx]      <= (cnt0 == cnt1);
          if (pidx == PIDX_LAST) begin
            resp_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= S_DONE;
          end else begin
            pidx  <= pidx + PIDX_W'(1);
            state <= S_LOAD;
          end
        end

        S_DONE: begin
          // Response and Tie stay put after the handshake until the next batch
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_response_engine.sv
// Randomised bench for ro_puf_response_engine: oscillators are driven from a random
// toggle schedule and each batch is predicted from the recorded per-cycle oscillator history.
module tb_ro_puf_response_engine;

  localparam int unsigned NUM_RO    = 12;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WINDOW    = 128;
  localparam int unsigned NUM_PAIRS = 4;
  localparam int unsigned CW        = NUM_PAIRS * SEL_W;
  localparam int unsigned LAT       = NUM_PAIRS * (WINDOW + 2);
  localparam int          CMAX      = (1 << CNT_W) - 1;
  localparam int          HIST      = 32768;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_RO-1:0]    RO_out = '0;
  logic                 start;
  logic [CW-1:0]        Cha0;
  logic [CW-1:0]        Cha1;
  logic                 busy;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [NUM_PAIRS-1:0] Response;
  logic [NUM_PAIRS-1:0] Tie;

  int                   total = 0;
  int                   bad   = 0;
  int                   cyc   = 0;
  logic [NUM_RO-1:0]    hist [HIST];
  int                   hold [NUM_RO];

  ro_puf_response_engine #(
    .NUM_RO    (NUM_RO),
    .SEL_W     (SEL_W),
    .CNT_W     (CNT_W),
    .WINDOW    (WINDOW),
    .NUM_PAIRS (NUM_PAIRS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RO_out     (RO_out),
    .start      (start),
    .Cha0       (Cha0),
    .Cha1       (Cha1),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .Response   (Response),
    .Tie        (Tie)
  );

  always #5 clk = ~clk;

  // hist[j] is the oscillator vector present at rising clock edge number j
  always @(posedge clk) begin
    hist[cyc] <= RO_out;
    cyc       <= cyc + 1;
  end

  // RO0..RO3 toggle every 3 clocks (saturate the counter); the rest are slow and jittery
  always @(negedge clk) begin
    for (int j = 0; j < NUM_RO; j++) begin
      if (hold[j] == 0) begin
        RO_out[j] <= ~RO_out[j];
        hold[j]   <= (j < 4) ? 2 : int'($urandom_range(13, 5));
      end else begin
        hold[j] <= hold[j] - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] pack(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
    logic [CW-1:0] r;
    r = '0;
    r[0*SEL_W +: SEL_W] = SEL_W'(a);
    r[1*SEL_W +: SEL_W] = SEL_W'(b);
    r[2*SEL_W +: SEL_W] = SEL_W'(c);
    r[3*SEL_W +: SEL_W] = SEL_W'(d);
    return r;
  endfunction

  // Rising edges of oscillator s seen by the counter at clock edges first..last;
  // the synchroniser makes edge m reflect the oscillator at edges m-2 and m-3
  function automatic int edges(input int s, input int first, input int last);
    int n;
    n = 0;
    if (s >= NUM_RO) return 0;
    for (int m = first; m <= last; m++)
      if (hist[m-2][s] && !hist[m-3][s]) n++;
    return (n > CMAX) ? CMAX : n;
  endfunction

  // Pair p counts during clock edges k+p*(WINDOW+2)+2 .. +WINDOW+1 after start at edge k
  task automatic model(input int k, input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                       output logic [NUM_PAIRS-1:0] er, output logic [NUM_PAIRS-1:0] et);
    int base, n0, n1;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      base  = k + p * int'(WINDOW + 2);
      n0    = edges(int'(c0[p*SEL_W +: SEL_W]), base + 2, base + int'(WINDOW) + 1);
      n1    = edges(int'(c1[p*SEL_W +: SEL_W]), base + 2, base + int'(WINDOW) + 1);
      er[p] = (n0 > n1);
      et[p] = (n0 == n1);
    end
  endtask

  task automatic run_req(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                         input bit scramble, input int stall);
    int k;
    bit seen;
    logic [NUM_PAIRS-1:0] er, et;
    @(negedge clk);
    Cha0  = c0;
    Cha1  = c1;
    start = 1'b1;
    k     = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_on", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < int'(LAT) + 20; i++) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      if (scramble) begin
        Cha0 = CW'($urandom);
        Cha1 = CW'($urandom);
      end
      @(negedge clk);
    end
    if (!seen) begin
      check("valid_timeout", 32'(resp_valid), 32'd1);
      return;
    end
    check("latency", 32'(cyc - k - 1), 32'(LAT));
    model(k, c0, c1, er, et);
    check("response", 32'(Response), 32'(er));
    check("tie", 32'(Tie), 32'(et));
    check("busy_done", 32'(busy), 32'd0);
    for (int i = 0; i < stall; i++) begin
      start = (i == stall / 2);
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_resp", 32'(Response), 32'(er));
      check("hold_tie", 32'(Tie), 32'(et));
    end
    start      = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("valid_clr", 32'(resp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("resp_keep", 32'(Response), 32'(er));
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    resp_ready = 1'b0;
    Cha0       = '0;
    Cha1       = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_resp", 32'(Response), 32'd0);
    check("rst_tie", 32'(Tie), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // fast/slow, slow/fast, same index, out-of-range vs RO0
    run_req(pack(1, 15, 5, 13), pack(8, 0, 5, 0), 1'b0, 0);
    // both saturated, both out of range, mixed
    run_req(pack(0, 1, 14, 2), pack(1, 2, 15, 9), 1'b0, 2);
    // challenges scrambled while counting, long backpressure with a stray start
    run_req(pack(3, 7, 11, 6), pack(9, 4, 10, 6), 1'b1, 10);
    for (int r = 0; r < 8; r++)
      run_req(CW'($urandom), CW'($urandom), bit'($urandom_range(1, 0)),
              int'($urandom_range(3, 0)));

    // Reset asserted asynchronously in the middle of pair 1's counting window
    @(negedge clk);
    Cha0  = pack(1, 15, 5, 13);
    Cha1  = pack(8, 0, 5, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (int'(WINDOW) + 2 + 40) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(resp_valid), 32'd0);
    check("arst_resp", 32'(Response), 32'd0);
    check("arst_tie", 32'(Tie), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_valid", 32'(resp_valid), 32'd0);
    run_req(pack(1, 15, 5, 13), pack(8, 0, 5, 0), 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
